jetson_spi_slave: RTL and testbench

- FPGA-side SPI slave terminating the Jetson link.
- Deserialises 32-bit frames of {index[3:0], data[27:0]}, MSB first, into a one-cycle receive strobe.
- Simultaneously shifts out one response frame: a pending outbound word from the channel mux, or the channel-0 status word when none is pending.
- Sits between the SPI pins and the per-channel command/response FIFOs.

---
 rtl/jetson_spi_slave.sv | 136 +++++++++++++
 tb/tb_jetson_spi_slave.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jetson_spi_slave.sv
// SPI mode-0 slave for the Jetson link: 32-bit {index, data} frames in, one response frame out per CS window.
// Optional aborted-frame counter built only when JETSON_SPI_FRAME_ERR_CNT_EN is defined.
module jetson_spi_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_BITS  = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_clk,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        rx_valid,
   output logic [3:0]  rx_index,
   output logic [27:0] rx_data,
   input  logic        tx_valid,
   input  logic [3:0]  tx_index,
   input  logic [27:0] tx_data,
   output logic        tx_ready,
   input  logic [27:0] status,
   output logic [7:0]  frame_err_cnt
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
   localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);

   logic [SYNC_STAGES-1:0] sclk_q, scs_q, smosi_q;
   logic                   sclk_prev_q, scs_prev_q;
   logic                   sclk_s, scs_s, smosi_s;
   logic                   clk_rise, clk_fall, cs_rise, cs_fall;

   state_t                 state_q;
   logic [5:0]             cnt_q;
   logic [FRAME_BITS-1:0]  rx_shift_q, tx_shift_q;
   logic                   tx_owned_q;
   logic [FRAME_BITS-1:0]  resp;

   // Synchronisers reset low so a CS already low at reset release never looks like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q      <= '0;
         scs_q       <= '0;
         smosi_q     <= '0;
         sclk_prev_q <= 1'b0;
         scs_prev_q  <= 1'b0;
      end else begin
         sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
         scs_q       <= {scs_q[SYNC_STAGES-2:0], spi_cs};
         smosi_q     <= {smosi_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev_q <= sclk_s;
         scs_prev_q  <= scs_s;
      end
   end

   assign sclk_s   = sclk_q[SYNC_STAGES-1];
   assign scs_s    = scs_q[SYNC_STAGES-1];
   assign smosi_s  = smosi_q[SYNC_STAGES-1];
   assign clk_rise = sclk_s & ~sclk_prev_q;
   assign clk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise  = scs_s & ~scs_prev_q;
   assign cs_fall  = ~scs_s & scs_prev_q;

   assign resp = tx_valid ? {tx_index, tx_data} : {4'h0, status};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         tx_owned_q <= 1'b0;
         spi_miso   <= 1'b0;
         rx_valid   <= 1'b0;
         rx_index   <= '0;
         rx_data    <= '0;
         tx_ready   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_ready <= 1'b0;
         case (state_q)
            IDLE: if (cs_fall) state_q <= LOAD;
            LOAD: begin
               tx_shift_q <= resp;
               tx_owned_q <= tx_valid;
               spi_miso   <= resp[FRAME_BITS-1];
               cnt_q      <= '0;
               state_q    <= SHIFT;
            end
            SHIFT: begin
               if (cs_rise) begin
                  if (cnt_q == CNT_FULL) begin
                     rx_valid <= 1'b1;
                     rx_index <= rx_shift_q[FRAME_BITS-1 -: 4];
                     rx_data  <= rx_shift_q[27:0];
                     tx_ready <= tx_owned_q;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= IDLE;
                  end
               end else begin
                  if (clk_rise) begin
                     rx_shift_q <= {rx_shift_q[FRAME_BITS-2:0], smosi_s};
                     if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 6'd1;
                  end
                  // Next MISO bit comes from the pre-shift register, so bit 30 follows bit 31.
                  if (clk_fall) begin
                     tx_shift_q <= {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                     spi_miso   <= tx_shift_q[FRAME_BITS-2];
                  end
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef JETSON_SPI_FRAME_ERR_CNT_EN
   logic       abort;
   logic [7:0] err_cnt_q;

   assign abort = (state_q == SHIFT) && cs_rise && (cnt_q != CNT_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          err_cnt_q <= '0;
      else if (abort && err_cnt_q != '1)   err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign frame_err_cnt = err_cnt_q;
`else
   assign frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_jetson_spi_slave.sv
// Bench for jetson_spi_slave: table of SPI frames plus reset and abort-saturation sequences,
// with received frames checked against a scoreboard queue.
module tb_jetson_spi_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_clk, spi_cs, spi_mosi, spi_miso;
   logic        rx_valid, tx_valid, tx_ready;
   logic [3:0]  rx_index, tx_index;
   logic [27:0] rx_data, tx_data, status;
   logic [7:0]  frame_err_cnt;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0;
   int txr_cnt = 0;
   logic [31:0] sbq[$];

`ifdef JETSON_SPI_FRAME_ERR_CNT_EN
   localparam logic [7:0] EXP_ERR_VEC = 8'd2;
   localparam logic [7:0] EXP_ERR_SAT = 8'hFF;
`else
   localparam logic [7:0] EXP_ERR_VEC = 8'd0;
   localparam logic [7:0] EXP_ERR_SAT = 8'd0;
`endif

   jetson_spi_slave #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .rx_valid(rx_valid), .rx_index(rx_index), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_index(tx_index), .tx_data(tx_data), .tx_ready(tx_ready),
      .status(status), .frame_err_cnt(frame_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every rx_valid cycle must match the oldest expected frame.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %h expected no frame", {rx_index, rx_data});
         end else begin
            check("rx_frame", {rx_index, rx_data}, sbq.pop_front());
         end
      end
      if (tx_ready) txr_cnt++;
   end

   task automatic spi_bits(input logic [31:0] w, input int nbits, input logic [27:0] st_mid,
                           inout logic [31:0] got);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = (i < 32) ? w[31-i] : 1'b0;
         if (i == 16) status = st_mid;
         repeat (8) @(negedge clk);
         spi_clk = 1'b1;
         got = {got[30:0], spi_miso};
         repeat (8) @(negedge clk);
         spi_clk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] w, input int nbits, input logic [27:0] st_mid,
                             output logic [31:0] got);
      got = '0;
      spi_cs = 1'b0;
      repeat (8) @(negedge clk);
      spi_bits(w, nbits, st_mid, got);
      repeat (8) @(negedge clk);
      spi_cs = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] mosi;
      int          nbits;
      logic        txv;
      logic [3:0]  txi;
      logic [27:0] txd;
      logic [27:0] st;
      logic [27:0] st_mid;
      logic [31:0] exp_miso;
      logic        exp_rx;
      logic        exp_txr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] got;
      int r0, t0;

      vecs[0] = '{32'h30ABCDEF, 32, 1'b0, 4'h0, 28'h0,       28'h1234567, 28'h1234567, 32'h01234567, 1'b1, 1'b0};
      vecs[1] = '{32'h00000000, 32, 1'b1, 4'h5, 28'h0000042, 28'h1234567, 28'h1234567, 32'h50000042, 1'b1, 1'b1};
      vecs[2] = '{32'hA5A5A5A5, 17, 1'b1, 4'h7, 28'h0123456, 28'h1234567, 28'h1234567, 32'h0,        1'b0, 1'b0};
      vecs[3] = '{32'h12345678, 32, 1'b1, 4'h7, 28'h0123456, 28'h1234567, 28'h1234567, 32'h70123456, 1'b1, 1'b1};
      vecs[4] = '{32'hDEADBEEF, 32, 1'b0, 4'h0, 28'h0,       28'h0000001, 28'h0000002, 32'h00000001, 1'b1, 1'b0};
      vecs[5] = '{32'h00000001, 32, 1'b0, 4'h0, 28'h0,       28'h0000002, 28'h0000002, 32'h00000002, 1'b1, 1'b0};
      vecs[6] = '{32'hFFFFFFFF, 34, 1'b1, 4'h9, 28'hFFFFFFF, 28'h0000002, 28'h0000002, 32'h0,        1'b0, 1'b0};
      vecs[7] = '{32'h0C0FFEE0, 32, 1'b1, 4'h9, 28'hFFFFFFF, 28'h0000002, 28'h0000002, 32'h9FFFFFFF, 1'b1, 1'b1};

      rst_n = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
      tx_valid = 1'b0; tx_index = '0; tx_data = '0; status = '0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_miso", {31'd0, spi_miso}, 32'd0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_frame", {rx_index, rx_data}, 32'd0);
      check("reset_tx_ready", {31'd0, tx_ready}, 32'd0);
      check("reset_err_cnt", {24'd0, frame_err_cnt}, 32'd0);

      foreach (vecs[k]) begin
         tx_valid = vecs[k].txv; tx_index = vecs[k].txi; tx_data = vecs[k].txd;
         status = vecs[k].st;
         r0 = rx_cnt; t0 = txr_cnt;
         if (vecs[k].exp_rx) sbq.push_back(vecs[k].mosi);
         send_frame(vecs[k].mosi, vecs[k].nbits, vecs[k].st_mid, got);
         if (vecs[k].nbits == 32) check($sformatf("vec%0d_miso", k), got, vecs[k].exp_miso);
         check($sformatf("vec%0d_rx_pulses", k), rx_cnt - r0, {31'd0, vecs[k].exp_rx});
         check($sformatf("vec%0d_tx_ready_pulses", k), txr_cnt - t0, {31'd0, vecs[k].exp_txr});
      end
      tx_valid = 1'b0;
      check("err_cnt_after_vectors", {24'd0, frame_err_cnt}, {24'd0, EXP_ERR_VEC});

      // Reset in the middle of a frame, released while CS is still low.
      status = 28'h5555555;
      r0 = rx_cnt;
      got = '0;
      spi_cs = 1'b0;
      repeat (8) @(negedge clk);
      spi_bits(32'hFFFFFFFF, 10, 28'h5555555, got);
      rst_n = 1'b0;
      #1;
      check("midrst_miso", {31'd0, spi_miso}, 32'd0);
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_rx_frame", {rx_index, rx_data}, 32'd0);
      check("midrst_tx_ready", {31'd0, tx_ready}, 32'd0);
      check("midrst_err_cnt", {24'd0, frame_err_cnt}, 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      spi_bits(32'hFFFFFFFF, 5, 28'h5555555, got);
      repeat (8) @(negedge clk);
      spi_cs = 1'b1;
      repeat (16) @(negedge clk);
      check("partial_frame_ignored", rx_cnt - r0, 32'd0);
      check("partial_frame_no_err", {24'd0, frame_err_cnt}, 32'd0);

      sbq.push_back(32'hFFFFFFFF);
      send_frame(32'hFFFFFFFF, 32, 28'h5555555, got);
      check("post_reset_miso", got, 32'h05555555);
      check("post_reset_rx_pulses", rx_cnt - r0, 32'd1);

      r0 = rx_cnt; t0 = txr_cnt;
      for (int n = 0; n < 300; n++) send_frame(32'h0, 1 + (n % 3), status, got);
      check("err_cnt_saturated", {24'd0, frame_err_cnt}, {24'd0, EXP_ERR_SAT});
      check("aborts_no_rx", rx_cnt - r0, 32'd0);
      check("aborts_no_tx_ready", txr_cnt - t0, 32'd0);
      check("scoreboard_drained", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
